bus_window_ctrl: RTL and testbench

Parametrised CPU-bus-to-SRAM cycle controller for the ROMulator, sitting between the 6502 socket pins and the internal 64K SRAM. It replaces fixed chip-select decode with NUM_WIN runtime-loaded address windows, each carrying enable, read-only and VRAM-mirror attributes. It tracks each phi2 bus cycle with a state machine and arbitrates SRAM ownership between the CPU and the diagnostics halt handshake.

---
 rtl/bus_window_ctrl_if.sv | 16 +
 rtl/bus_window_ctrl.sv | 150 +++++++++++++++
 tb/tb_bus_window_ctrl.sv | 275 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/bus_window_ctrl_if.sv
// bus_window_ctrl_if: 6502 socket bus between the CPU pins and the window controller
interface bus_window_ctrl_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 8
);
    logic [ADDR_W-1:0] cpu_addr;
    logic              cpu_phi2;
    logic              cpu_rwbar;
    logic [DATA_W-1:0] cpu_wdata;
    logic [DATA_W-1:0] cpu_rdata;
    logic              bus_drive;
    logic              bus_hit;
    logic              rdy;
    modport master (output cpu_addr, cpu_phi2, cpu_rwbar, cpu_wdata, input cpu_rdata, bus_drive, bus_hit, rdy);
    modport slave (input cpu_addr, cpu_phi2, cpu_rwbar, cpu_wdata, output cpu_rdata, bus_drive, bus_hit, rdy);
endinterface

// File: rtl/bus_window_ctrl.sv
// bus_window_ctrl: 6502-bus to SRAM cycle controller with runtime address windows; ROMULATOR_VRAM_MIRROR_EN enables the VRAM mirror port
module bus_window_ctrl #(
    parameter int ADDR_W  = 16,
    parameter int DATA_W  = 8,
    parameter int NUM_WIN = 4,
    parameter int VRAM_AW = 11,
    localparam int IW     = NUM_WIN > 1 ? $clog2(NUM_WIN) : 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               loaded,
    input  logic               tbl_we,
    input  logic [IW-1:0]      tbl_idx,
    input  logic [ADDR_W-1:0]  tbl_start,
    input  logic [ADDR_W-1:0]  tbl_end,
    input  logic [2:0]         tbl_attr,
    bus_window_ctrl_if.slave   cpu,
    input  logic               halt_req,
    output logic               halt_ack,
    input  logic [ADDR_W-1:0]  diag_addr,
    input  logic               diag_cs,
    input  logic               diag_we,
    input  logic [DATA_W-1:0]  diag_wdata,
    output logic [ADDR_W-1:0]  ram_addr,
    output logic               ram_cs,
    output logic               ram_we,
    output logic [DATA_W-1:0]  ram_wdata,
    input  logic [DATA_W-1:0]  ram_rdata,
    output logic               vram_we,
    output logic [VRAM_AW-1:0] vram_waddr,
    output logic [DATA_W-1:0]  vram_wdata,
    output logic [7:0]         wp_count
);
    localparam logic [2:0] IDLE = 3'd0, DECODE = 3'd1, READ = 3'd2, RHOLD = 3'd3, WRITE = 3'd4, HALTED = 3'd5;
    logic [2:0]         state, state_n, nxt;
    logic               phi2_m, phi2_s, phi2_d, rise, fall;
    logic [ADDR_W-1:0]  win_start [NUM_WIN];
    logic [ADDR_W-1:0]  win_end [NUM_WIN];
    logic [NUM_WIN-1:0] win_en, win_ro, win_vr;
    logic [ADDR_W-1:0]  addr_q, hit_start;
    logic [DATA_W-1:0]  wdata_q, rdata_q;
    logic               rw_q, ro_q, hit, hit_ro, hit_vr;
    logic               drive_q, hit_q, rdy_q, wr_fall, halted;
    logic [7:0]         wp_q;

    assign rise    = phi2_s && !phi2_d;
    assign fall    = !phi2_s && phi2_d;
    assign halted  = loaded && state == HALTED;
    assign wr_fall = loaded && state == WRITE && fall;

    // Descending scan so the lowest matching index wins; end==0 stands for the top of the address space
    always_comb begin
        hit = 1'b0;
        hit_ro = 1'b0;
        hit_vr = 1'b0;
        hit_start = '0;
        for (int i = NUM_WIN - 1; i >= 0; i--)
            if (win_en[i] && addr_q >= win_start[i] && (addr_q < win_end[i] || win_end[i] == '0) && win_start[i] != win_end[i]) begin
                hit = 1'b1;
                hit_ro = win_ro[i];
                hit_vr = win_vr[i];
                hit_start = win_start[i];
            end
    end

    always_comb begin
        nxt = IDLE;
        case (state)
            IDLE:         nxt = rise ? DECODE : (halt_req && !phi2_s) ? HALTED : IDLE;
            DECODE:       nxt = fall ? IDLE : !hit ? RHOLD : rw_q ? READ : WRITE;
            READ:         nxt = fall ? IDLE : RHOLD;
            RHOLD, WRITE: nxt = fall ? IDLE : state;
            HALTED:       nxt = halt_req ? HALTED : IDLE;
            default:      nxt = IDLE;
        endcase
        state_n = loaded ? nxt : IDLE;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            {phi2_m, phi2_s, phi2_d} <= '0;
            state <= IDLE;
            rdata_q <= '0;
            drive_q <= 1'b0;
            hit_q <= 1'b0;
            rdy_q <= 1'b0;
            wp_q <= '0;
            win_en <= '0;
        end else begin
            {phi2_d, phi2_s, phi2_m} <= {phi2_s, phi2_m, cpu.cpu_phi2};
            state <= state_n;
            rdy_q <= loaded && !halt_req && state_n != HALTED;
            drive_q <= state_n == RHOLD && (drive_q || state == READ);
            hit_q <= state_n != IDLE && state_n != HALTED && (state == DECODE ? hit : hit_q);
            wp_q <= wp_q + {7'd0, wr_fall && ro_q && wp_q != 8'hFF};
            if (state == READ && state_n == RHOLD)
                rdata_q <= ram_rdata;
            if (tbl_we && !loaded)
                win_en[tbl_idx] <= tbl_attr[0];
        end
    end

    always_ff @(posedge clk) begin
        if (state == IDLE && rise) begin
            addr_q <= cpu.cpu_addr;
            rw_q <= cpu.cpu_rwbar;
        end
        if (phi2_s)
            wdata_q <= cpu.cpu_wdata;
        if (state == DECODE)
            ro_q <= hit_ro;
        if (tbl_we && !loaded) begin
            win_start[tbl_idx] <= tbl_start;
            win_end[tbl_idx] <= tbl_end;
            win_ro[tbl_idx] <= tbl_attr[1];
            win_vr[tbl_idx] <= tbl_attr[2];
        end
    end

    always_comb begin
        ram_addr = !loaded ? '0 : halted ? diag_addr : addr_q;
        ram_cs = halted ? diag_cs : loaded && ((state == DECODE && hit && rw_q) || (wr_fall && !ro_q));
        ram_we = halted ? diag_we : wr_fall && !ro_q;
        ram_wdata = !loaded ? '0 : halted ? diag_wdata : wdata_q;
    end

`ifdef ROMULATOR_VRAM_MIRROR_EN
    logic              vr_q;
    logic [ADDR_W-1:0] start_q;
    always_ff @(posedge clk)
        if (state == DECODE)
            {vr_q, start_q} <= {hit_vr, hit_start};
    assign vram_we    = wr_fall && !ro_q && vr_q;
    assign vram_waddr = VRAM_AW'(addr_q - start_q);
    assign vram_wdata = wdata_q;
`else
    logic vram_unused;
    assign vram_unused = ^{hit_vr, hit_start};
    assign vram_we     = 1'b0;
    assign vram_waddr  = '0;
    assign vram_wdata  = '0;
`endif

    assign cpu.cpu_rdata = rdata_q;
    assign cpu.bus_drive = drive_q;
    assign cpu.bus_hit   = hit_q;
    assign cpu.rdy       = rdy_q;
    assign halt_ack      = halted;
    assign wp_count      = wp_q;
endmodule

// File: tb/tb_bus_window_ctrl.sv
// tb_bus_window_ctrl: directed bench for bus_window_ctrl with a 1-cycle-latency SRAM model
module tb_bus_window_ctrl;
    logic        clk;
    logic        rst;
    logic        loaded;
    logic        tbl_we;
    logic [1:0]  tbl_idx;
    logic [15:0] tbl_start, tbl_end;
    logic [2:0]  tbl_attr;
    logic        halt_req, halt_ack;
    logic [15:0] diag_addr;
    logic        diag_cs, diag_we;
    logic [7:0]  diag_wdata;
    logic [15:0] ram_addr;
    logic        ram_cs, ram_we;
    logic [7:0]  ram_wdata, ram_rdata;
    logic        vram_we;
    logic [10:0] vram_waddr;
    logic [7:0]  vram_wdata;
    logic [7:0]  wp_count;
    logic [7:0]  mem [65536];
    int          n_chk = 0, n_fail = 0, we_cnt = 0, vram_cnt = 0, w0;

`ifdef ROMULATOR_VRAM_MIRROR_EN
    localparam bit VR = 1'b1;
`else
    localparam bit VR = 1'b0;
`endif

    bus_window_ctrl_if #(.ADDR_W(16), .DATA_W(8)) bus ();

    bus_window_ctrl dut (
        .clk(clk), .rst(rst), .loaded(loaded), .tbl_we(tbl_we), .tbl_idx(tbl_idx),
        .tbl_start(tbl_start), .tbl_end(tbl_end), .tbl_attr(tbl_attr), .cpu(bus),
        .halt_req(halt_req), .halt_ack(halt_ack), .diag_addr(diag_addr), .diag_cs(diag_cs),
        .diag_we(diag_we), .diag_wdata(diag_wdata), .ram_addr(ram_addr), .ram_cs(ram_cs),
        .ram_we(ram_we), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata), .vram_we(vram_we),
        .vram_waddr(vram_waddr), .vram_wdata(vram_wdata), .wp_count(wp_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // SRAM model plus write-strobe counters, all in one process
    initial begin
        for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
        mem[16'hC123] = 8'h5A;
        mem[16'hC000] = 8'h11;
        mem[16'hFFFF] = 8'hEE;
        mem[16'h87FF] = 8'h3C;
        ram_rdata = 8'h00;
        forever begin
            @(posedge clk);
            if (ram_cs) begin
                ram_rdata <= mem[ram_addr];
                if (ram_we) begin
                    mem[ram_addr] = ram_wdata;
                    we_cnt++;
                end
            end
            if (vram_we) vram_cnt++;
        end
    end

    task automatic clk_n(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0h, want %0h", tag, obs, exp);
        end
    endtask

    task automatic load_win(input logic [1:0] i, input logic [15:0] s, input logic [15:0] e, input logic [2:0] a);
        tbl_we = 1'b1;
        tbl_idx = i;
        tbl_start = s;
        tbl_end = e;
        tbl_attr = a;
        clk_n(1);
        tbl_we = 1'b0;
    endtask

    task automatic probe_read(input string tag, input logic [15:0] a, input logic h, input logic [7:0] d);
        bus.cpu_addr = a;
        bus.cpu_rwbar = 1'b1;
        bus.cpu_phi2 = 1'b1;
        clk_n(5);
        chk({tag, "_hit"}, 32'(bus.bus_hit), 32'(h));
        chk({tag, "_drive"}, 32'(bus.bus_drive), 32'(h));
        if (h) chk({tag, "_data"}, 32'(bus.cpu_rdata), 32'(d));
        clk_n(3);
        bus.cpu_phi2 = 1'b0;
        clk_n(4);
    endtask

    task automatic wr_cycle(input logic [15:0] a, input logic [7:0] d);
        bus.cpu_addr = a;
        bus.cpu_rwbar = 1'b0;
        bus.cpu_wdata = d;
        bus.cpu_phi2 = 1'b1;
        clk_n(8);
        bus.cpu_phi2 = 1'b0;
        clk_n(4);
        bus.cpu_rwbar = 1'b1;
    endtask

    initial begin
        rst = 1'b0; loaded = 1'b0; tbl_we = 1'b0; tbl_idx = '0; tbl_start = '0; tbl_end = '0; tbl_attr = '0;
        halt_req = 1'b0; diag_addr = '0; diag_cs = 1'b0; diag_we = 1'b0; diag_wdata = '0;
        bus.cpu_addr = '0; bus.cpu_phi2 = 1'b0; bus.cpu_rwbar = 1'b1; bus.cpu_wdata = '0;
        clk_n(3);
        chk("rst_drive", 32'(bus.bus_drive), 0);
        chk("rst_hit", 32'(bus.bus_hit), 0);
        chk("rst_rdy", 32'(bus.rdy), 0);
        chk("rst_rdata", 32'(bus.cpu_rdata), 0);
        chk("rst_ack", 32'(halt_ack), 0);
        chk("rst_ram", 32'({ram_cs, ram_we, vram_we}), 0);
        chk("rst_wp", 32'(wp_count), 0);
        rst = 1'b1;
        load_win(2'd0, 16'hC000, 16'h0000, 3'b011);
        load_win(2'd1, 16'h8000, 16'h8800, 3'b101);
        load_win(2'd3, 16'h7000, 16'h7000, 3'b001);
        loaded = 1'b1;
        clk_n(2);
        chk("rdy_up", 32'(bus.rdy), 1);
        load_win(2'd3, 16'h5000, 16'h6000, 3'b001);
        // Read 0xC123: ram_cs at DECODE, data and drive 5 clk after pin rise
        bus.cpu_addr = 16'hC123;
        bus.cpu_rwbar = 1'b1;
        bus.cpu_phi2 = 1'b1;
        clk_n(3);
        chk("dec_cs", 32'(ram_cs), 1);
        chk("dec_addr", 32'(ram_addr), 32'hC123);
        chk("dec_drive", 32'(bus.bus_drive), 0);
        clk_n(1);
        chk("rd_cs", 32'(ram_cs), 0);
        chk("rd_drive", 32'(bus.bus_drive), 0);
        clk_n(1);
        chk("rh_drive", 32'(bus.bus_drive), 1);
        chk("rh_data", 32'(bus.cpu_rdata), 32'h5A);
        chk("rh_hit", 32'(bus.bus_hit), 1);
        clk_n(3);
        bus.cpu_phi2 = 1'b0;
        clk_n(2);
        chk("fall_hold", 32'(bus.bus_drive), 1);
        clk_n(1);
        chk("fall_drive", 32'(bus.bus_drive), 0);
        chk("fall_hit", 32'(bus.bus_hit), 0);
        clk_n(2);
        probe_read("start_incl", 16'hC000, 1'b1, 8'h11);
        probe_read("below", 16'hBFFF, 1'b0, 8'h00);
        probe_read("top", 16'hFFFF, 1'b1, 8'hEE);
        probe_read("end_m1", 16'h87FF, 1'b1, 8'h3C);
        probe_read("end_excl", 16'h8800, 1'b0, 8'h00);
        probe_read("empty_win", 16'h7000, 1'b0, 8'h00);
        probe_read("late_tbl", 16'h5000, 1'b0, 8'h00);
        // Write to read-only window
        w0 = we_cnt;
        wr_cycle(16'hC010, 8'h77);
        chk("ro_we", 32'(we_cnt), 32'(w0));
        chk("ro_wp", 32'(wp_count), 1);
        chk("ro_mem", 32'(mem[16'hC010]), 0);
        // Write to VRAM-mirrored window, data changed mid-cycle
        bus.cpu_addr = 16'h8123;
        bus.cpu_rwbar = 1'b0;
        bus.cpu_wdata = 8'h40;
        bus.cpu_phi2 = 1'b1;
        clk_n(4);
        chk("vw_hit", 32'(bus.bus_hit), 1);
        bus.cpu_wdata = 8'h41;
        clk_n(2);
        bus.cpu_phi2 = 1'b0;
        clk_n(1);
        chk("vw_early", 32'(ram_we), 0);
        clk_n(1);
        chk("vw_we", 32'({ram_cs, ram_we}), 3);
        chk("vw_addr", 32'(ram_addr), 32'h8123);
        chk("vw_wdata", 32'(ram_wdata), 32'h41);
        chk("vw_vwe", 32'(vram_we), 32'(VR));
        chk("vw_vaddr", 32'(vram_waddr), VR ? 32'h123 : 32'h0);
        chk("vw_vdata", 32'(vram_wdata), VR ? 32'h41 : 32'h0);
        clk_n(1);
        chk("vw_mem", 32'(mem[16'h8123]), 32'h41);
        chk("vw_off", 32'(ram_we), 0);
        chk("vw_cnt", 32'(vram_cnt), 32'(VR));
        bus.cpu_rwbar = 1'b1;
        clk_n(2);
        // Halt requested during a read cycle
        bus.cpu_addr = 16'hC123;
        bus.cpu_phi2 = 1'b1;
        clk_n(4);
        halt_req = 1'b1;
        clk_n(1);
        chk("h_rdy", 32'(bus.rdy), 0);
        chk("h_ack_early", 32'(halt_ack), 0);
        chk("h_drive", 32'(bus.bus_drive), 1);
        clk_n(3);
        bus.cpu_phi2 = 1'b0;
        clk_n(3);
        chk("h_ack_idle", 32'(halt_ack), 0);
        clk_n(1);
        chk("h_ack", 32'(halt_ack), 1);
        diag_addr = 16'h0200;
        diag_wdata = 8'h99;
        diag_cs = 1'b1;
        diag_we = 1'b1;
        bus.cpu_addr = 16'hC123;
        #1;
        chk("d_addr", 32'(ram_addr), 32'h0200);
        chk("d_we", 32'({ram_cs, ram_we}), 3);
        chk("d_wdata", 32'(ram_wdata), 32'h99);
        clk_n(1);
        diag_cs = 1'b0;
        diag_we = 1'b0;
        chk("d_mem", 32'(mem[16'h0200]), 32'h99);
        halt_req = 1'b0;
        clk_n(1);
        chk("rel_ack", 32'(halt_ack), 0);
        chk("rel_rdy", 32'(bus.rdy), 1);
        clk_n(2);
        // Overlapping windows: lowest index wins
        loaded = 1'b0;
        clk_n(1);
        load_win(2'd0, 16'h1000, 16'h2000, 3'b011);
        load_win(2'd2, 16'h0000, 16'h4000, 3'b001);
        loaded = 1'b1;
        clk_n(2);
        w0 = we_cnt;
        wr_cycle(16'h1800, 8'h11);
        chk("ov_blk_we", 32'(we_cnt), 32'(w0));
        chk("ov_blk_mem", 32'(mem[16'h1800]), 0);
        chk("ov_blk_wp", 32'(wp_count), 2);
        wr_cycle(16'h3000, 8'h22);
        chk("ov_ok_mem", 32'(mem[16'h3000]), 32'h22);
        chk("ov_ok_we", 32'(we_cnt), 32'(w0 + 1));
        // Saturate the blocked-write counter
        repeat (253) wr_cycle(16'h1800, 8'h33);
        chk("wp_255", 32'(wp_count), 255);
        wr_cycle(16'h1800, 8'h33);
        chk("wp_sat", 32'(wp_count), 255);
        chk("sat_mem", 32'(mem[16'h1800]), 0);
        // Reset in WRITE before the phi2 fall
        w0 = we_cnt;
        bus.cpu_addr = 16'h3100;
        bus.cpu_rwbar = 1'b0;
        bus.cpu_wdata = 8'h55;
        bus.cpu_phi2 = 1'b1;
        clk_n(4);
        chk("mr_hit", 32'(bus.bus_hit), 1);
        rst = 1'b0;
        bus.cpu_phi2 = 1'b0;
        clk_n(1);
        chk("mr_hit0", 32'(bus.bus_hit), 0);
        chk("mr_drive", 32'(bus.bus_drive), 0);
        chk("mr_rdy", 32'(bus.rdy), 0);
        chk("mr_rdata", 32'(bus.cpu_rdata), 0);
        chk("mr_wp", 32'(wp_count), 0);
        chk("mr_ram", 32'({ram_cs, ram_we, vram_we, halt_ack}), 0);
        rst = 1'b1;
        bus.cpu_rwbar = 1'b1;
        clk_n(1);
        chk("mr_rdy1", 32'(bus.rdy), 1);
        clk_n(4);
        chk("mr_nowr", 32'(we_cnt), 32'(w0));
        chk("mr_mem", 32'(mem[16'h3100]), 0);
        probe_read("en_clr", 16'h3000, 1'b0, 8'h00);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
